goose_anim_sequencer: RTL
=========================

# goose_anim_sequencer

Frame-synchronous animation scheduler for the goose sprite datapath. Replaces the ad-hoc frame counter in the top level. Consumes a once-per-video-frame tick and user controls (run, single-step, speed, direction). Drives the 2-bit sprite frame select into the frame LUT mux and the free-running 7-bit video frame counter consumed by the sound module.

## Interface
Parameters:
- `NUM_FRAMES`, 4: sprite frames in the animation loop. Must be a power of two; 4 is the only supported value.
- `CNT_W`, 7: width of the free-running video frame counter.

Ports:
- `clk`  in  1  pixel clock
- `reset`  in  1  asynchronous, active-high reset
- `frame_tick`  in  1  one-cycle pulse at pixel (0,0) of each video frame
- `run`  in  1  level; 1 = continuous playback
- `step_req`  in  1  one-cycle pulse; request a single-frame advance while paused
- `speed`  in  2  hold length in video frames = 2^(speed+1): 00→2, 01→4, 10→8, 11→16
- `reverse`  in  1  1 = frame_num decrements
- `frame_num`  out  2  current sprite frame select
- `frame_counter`  out  CNT_W  free-running video frame count
- `anim_step`  out  1  one-cycle pulse, registered with each frame_num change
- `loop_done`  out  1  one-cycle pulse when frame_num wraps
- `playing`  out  1  1 while in PLAYING

## Operation
- FSM states are PAUSED, STEP_PEND and PLAYING. Reset state is PAUSED.
- All state, counter and output updates occur only on cycles with `frame_tick`=1. The one exception is `step_req` latching.
- frame_counter: +1 on every tick in every state. Wraps 127→0.
- PAUSED:
  - `step_req`=1 with no tick in the same cycle → STEP_PEND.
  - Tick with `run`=1 → PLAYING, hold_cnt←0, no advance.
  - Tick with `run`=0 and `step_req`=1 in the same cycle → advance immediately, remain PAUSED.
- STEP_PEND:
  - On tick: advance.
  - Next state is PLAYING if `run`=1 (hold_cnt←0), else PAUSED.
  - Further `step_req` pulses are ignored. There is no queue.
- PLAYING:
  - `step_req` is ignored.
  - On tick with `run`=0 → PAUSED, no advance.
  - On tick with `run`=1: if hold_cnt ≥ 2^(speed+1)−1, advance and hold_cnt←0. Otherwise hold_cnt+1.
  - `speed` is sampled each tick. Lowering speed below the current hold_cnt causes an advance on the next tick, because the compare is ≥.
- Advance:
  - `reverse`=0: frame_num←frame_num+1 mod 4. `reverse`=1: frame_num←frame_num−1 mod 4.
  - Asserts `anim_step`.
  - Asserts `loop_done` on a 3→0 (forward) or 0→3 (reverse) transition.
- hold_cnt is 4 bits and internal. It never exceeds 15.

## Timing
- Reset values: frame_num=0, frame_counter=0, anim_step=0, loop_done=0, playing=0, hold_cnt=0, state=PAUSED.
- Reset asserted mid-operation clears everything immediately (asynchronous). The first tick after release is handled as PAUSED.
- Latency: tick in cycle t → updated frame_num, frame_counter and pulses valid in cycle t+1. Pulses last exactly one cycle.
- `playing` is registered and changes in the cycle after the tick that causes the transition.
- `step_req` latch: pulse in cycle t (no tick) → state=STEP_PEND in cycle t+1. frame_num does not change until the next tick.
- Inputs `run`, `speed` and `reverse` are sampled only in the tick cycle. Their values between ticks are don't-care.
- Back-to-back ticks (testbench only) are legal. Each tick is processed independently.

## Structure
- Shared package `goose_pkg`:
  - state enum `anim_state_t` {PAUSED, STEP_PEND, PLAYING}
  - `NUM_FRAMES`
  - `CNT_W`
  - function `hold_len(speed)` returning 4-bit 2^(speed+1)−1
- Top level:
  - instantiates the block with `reset` = ~rst_n
  - `frame_tick` = (pix_x==0 && pix_y==0)
  - `run` = ui_in[2], `step_req` = rising edge of ui_in[3], `speed` = ui_in[5:4], `reverse` = ui_in[6]
- No sub-module. The hold counter and FSM live in one module.

## Test plan
- Reset, then 20 ticks with run=0 → frame_num stays 0, frame_counter=20, playing=0, no anim_step.
- run=1, speed=10, reverse=0, 33 ticks → the first tick only enters PLAYING. Advances occur on ticks 9, 17, 25 and 33. frame_num=0 after tick 33, with loop_done pulsing on tick 33.
- run=1, speed=00, reverse=1 from frame_num=0 → first advance gives frame_num=3 with loop_done=1. Subsequent values are 2, 1 at 2-tick intervals.
- Paused: step_req pulse 100 cycles before a tick → STEP_PEND, then frame_num 0→1 one cycle after the tick. A second step_req during STEP_PEND produces only one advance.
- PLAYING with speed=11 and hold_cnt=9 → set speed=00 → advance on the next tick, hold_cnt=0.
- Assert reset mid-hold, with frame_counter=127 and frame_num=2 → all outputs 0 in the same cycle. The first tick after release gives frame_counter=1.

Source files
------------

// File: rtl/goose_pkg.sv
// Shared types and constants for the goose sprite animation datapath.
package goose_pkg;

  typedef enum logic [1:0] {
    PAUSED    = 2'd0,
    STEP_PEND = 2'd1,
    PLAYING   = 2'd2
  } anim_state_t;

  localparam int unsigned NUM_FRAMES = 4;
  localparam int unsigned CNT_W      = 7;

  // Last hold_cnt value before an advance: 2^(speed+1) - 1.
  function automatic logic [3:0] hold_len(input logic [1:0] speed);
    logic [4:0] len;
    len = 5'd2 << speed;
    return 4'(len - 5'd1);
  endfunction

endpackage

// File: rtl/goose_anim_sequencer.sv
// Frame-synchronous sprite animation scheduler: run/pause/single-step playback with
// selectable hold length and direction, plus a free-running video frame counter.
module goose_anim_sequencer #(
  parameter int unsigned NUM_FRAMES = goose_pkg::NUM_FRAMES,
  parameter int unsigned CNT_W      = goose_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             run,
  input  logic             step_req,
  input  logic [1:0]       speed,
  input  logic             reverse,
  output logic [1:0]       frame_num,
  output logic [CNT_W-1:0] frame_counter,
  output logic             anim_step,
  output logic             loop_done,
  output logic             playing
);
  import goose_pkg::*;

  localparam logic [1:0] LastFrame = 2'(NUM_FRAMES - 1);

  anim_state_t      state_q, state_d;
  logic [3:0]       hold_q, hold_d;
  logic [1:0]       frame_q, frame_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             loop_q, loop_d;
  logic             playing_q;
  logic             advance;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    advance = 1'b0;
    if (frame_tick) begin
      cnt_d = cnt_q + 1'b1;
      unique case (state_q)
        PAUSED: begin
          if (run) begin
            state_d = PLAYING;
            hold_d  = 4'd0;
          end else if (step_req) begin
            advance = 1'b1;
          end
        end
        STEP_PEND: begin
          advance = 1'b1;
          if (run) begin
            state_d = PLAYING;
            hold_d  = 4'd0;
          end else begin
            state_d = PAUSED;
          end
        end
        PLAYING: begin
          if (!run) begin
            state_d = PAUSED;
          // >= so that lowering speed mid-hold advances on the next tick
          end else if (hold_q >= hold_len(speed)) begin
            advance = 1'b1;
            hold_d  = 4'd0;
          end else begin
            hold_d = hold_q + 4'd1;
          end
        end
        default: state_d = PAUSED;
      endcase
    end else if (state_q == PAUSED && step_req) begin
      state_d = STEP_PEND;
    end
  end

  // Pulses default low every cycle so they last exactly one cycle.
  always_comb begin
    frame_d = frame_q;
    step_d  = 1'b0;
    loop_d  = 1'b0;
    if (advance) begin
      step_d = 1'b1;
      if (reverse) begin
        frame_d = frame_q - 2'd1;
        loop_d  = (frame_q == 2'd0);
      end else begin
        frame_d = frame_q + 2'd1;
        loop_d  = (frame_q == LastFrame);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= PAUSED;
      hold_q    <= 4'd0;
      frame_q   <= 2'd0;
      cnt_q     <= '0;
      step_q    <= 1'b0;
      loop_q    <= 1'b0;
      playing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      frame_q   <= frame_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      loop_q    <= loop_d;
      playing_q <= (state_d == PLAYING);
    end
  end

  assign frame_num     = frame_q;
  assign frame_counter = cnt_q;
  assign anim_step     = step_q;
  assign loop_done     = loop_q;
  assign playing       = playing_q;

endmodule
